// File: rtl/thread_status_unit.sv
// Thread status tracker for one thread group.
// Each hardware thread walks IDLE -> READY -> (STALL <-> READY) -> DONE.
// The scheduler sees the READY mask. The unit takes a new group only once no
// thread is READY or STALL.
module thread_status_unit #(
  parameter int NUM_THREADS     = 8,
  parameter int THREAD_ID_WIDTH = 3,
  parameter int STALL_CNT_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       launch_valid,
  input  logic [NUM_THREADS-1:0]     launch_mask,
  output logic                       launch_ready,
  input  logic                       issue_valid,
  input  logic [THREAD_ID_WIDTH-1:0] issue_thread,
  input  logic                       issue_stall,
  input  logic [STALL_CNT_WIDTH-1:0] issue_stall_cycles,
  input  logic                       issue_retire,
  output logic [NUM_THREADS-1:0]     active_threads,
  output logic                       busy,
  output logic                       done,
  output logic                       issue_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READY = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [NUM_THREADS-1:0][1:0]               st;
  logic [NUM_THREADS-1:0][STALL_CNT_WIDTH-1:0] cnt;
  logic [NUM_THREADS-1:0]                    ready_vec;
  logic [NUM_THREADS-1:0]                    busy_vec;
  logic [NUM_THREADS-1:0]                    lane_hit;
  logic                                      launch_acc;
  logic                                      issue_legal;
  logic                                      done_d;

  // A launch is only taken while idle, so it can never coincide with a legal issue.
  assign launch_acc  = launch_valid && !busy;
  assign issue_legal = |lane_hit;

  // Group completes when the retiring thread is the last one still READY or STALL.
  assign done_d = issue_legal && issue_retire && ((busy_vec & ~lane_hit) == '0);

  genvar i;
  generate
    for (i = 0; i < NUM_THREADS; i++) begin : g_lane
      assign ready_vec[i] = (st[i] == ST_READY);
      assign busy_vec[i]  = (st[i] == ST_READY) || (st[i] == ST_STALL);
      // An out-of-range thread index matches no lane and so reads as illegal.
      assign lane_hit[i]  = issue_valid && (32'(issue_thread) == i) && ready_vec[i];

      // Per-thread state and stall down-counter.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          st[i]  <= ST_IDLE;
          cnt[i] <= '0;
        end else if (launch_acc) begin
          st[i]  <= launch_mask[i] ? ST_READY : ST_IDLE;
          cnt[i] <= '0;
        end else if (lane_hit[i]) begin
          if (issue_retire) begin
            st[i] <= ST_DONE;
          end else if (issue_stall && issue_stall_cycles != '0) begin
            st[i]  <= ST_STALL;
            cnt[i] <= issue_stall_cycles;
          end
        end else if (st[i] == ST_STALL) begin
          if (cnt[i] == STALL_CNT_WIDTH'(1)) begin
            st[i]  <= ST_READY;
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] - STALL_CNT_WIDTH'(1);
          end
        end
      end
    end
  endgenerate

  // One-cycle status pulses, registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done      <= 1'b0;
      issue_err <= 1'b0;
    end else begin
      done      <= done_d;
      issue_err <= issue_valid && !issue_legal;
    end
  end

  assign active_threads = ready_vec;
  assign busy           = |busy_vec;
  assign launch_ready   = !busy;

endmodule

// File: tb/tb_thread_status_unit.sv
// Bench for thread_status_unit: directed scenarios plus randomized traffic
// checked against a per-thread behavioural model.
module tb_thread_status_unit;
  localparam int NT  = 8;
  localparam int TW  = 4;   // wide enough to present out-of-range ids such as 9
  localparam int SCW = 4;

  logic           clk = 0;
  logic           reset = 1;
  logic           launch_valid = 0;
  logic [NT-1:0]  launch_mask = '0;
  logic           launch_ready;
  logic           issue_valid = 0;
  logic [TW-1:0]  issue_thread = '0;
  logic           issue_stall = 0;
  logic [SCW-1:0] issue_stall_cycles = '0;
  logic           issue_retire = 0;
  logic [NT-1:0]  active_threads;
  logic           busy, done, issue_err;

  int n_checks = 0;
  int n_pass   = 0;

  // model: 0 idle, 1 ready, 2 stalled, 3 done; rem = stall cycles left
  int m_st[NT];
  int m_rem[NT];
  bit m_done, m_err;

  thread_status_unit #(.NUM_THREADS(NT), .THREAD_ID_WIDTH(TW), .STALL_CNT_WIDTH(SCW)) dut (
    .clk(clk), .reset(reset),
    .launch_valid(launch_valid), .launch_mask(launch_mask), .launch_ready(launch_ready),
    .issue_valid(issue_valid), .issue_thread(issue_thread), .issue_stall(issue_stall),
    .issue_stall_cycles(issue_stall_cycles), .issue_retire(issue_retire),
    .active_threads(active_threads), .busy(busy), .done(done), .issue_err(issue_err)
  );

  always #5 clk = ~clk;

  function automatic bit m_busy();
    for (int t = 0; t < NT; t++) if (m_st[t] == 1 || m_st[t] == 2) return 1;
    return 0;
  endfunction

  function automatic logic [NT-1:0] m_active();
    logic [NT-1:0] a = '0;
    for (int t = 0; t < NT; t++) a[t] = (m_st[t] == 1);
    return a;
  endfunction

  task automatic m_reset();
    for (int t = 0; t < NT; t++) begin m_st[t] = 0; m_rem[t] = 0; end
    m_done = 0; m_err = 0;
  endtask

  // Advance the model by one rising edge using the inputs presented at that edge.
  task automatic m_step();
    bit pre_busy, legal, acc;
    int tid;
    pre_busy = m_busy();
    tid      = int'(issue_thread);
    legal    = issue_valid && tid < NT && m_st[tid] == 1;
    acc      = launch_valid && !pre_busy;
    m_err    = issue_valid && !legal;
    for (int t = 0; t < NT; t++)
      if (m_st[t] == 2) begin
        m_rem[t]--;
        if (m_rem[t] == 0) m_st[t] = 1;
      end
    if (acc) begin
      for (int t = 0; t < NT; t++) begin m_st[t] = launch_mask[t] ? 1 : 0; m_rem[t] = 0; end
    end else if (legal) begin
      if (issue_retire) m_st[tid] = 3;
      else if (issue_stall && issue_stall_cycles != 0) begin
        m_st[tid] = 2; m_rem[tid] = int'(issue_stall_cycles);
      end
    end
    m_done = pre_busy && !m_busy() && legal && issue_retire;
  endtask

  // One clock: edge, model update, settle, then drop the one-shot valids.
  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
    launch_valid = 0;
    issue_valid  = 0;
  endtask

  task automatic do_launch(input logic [NT-1:0] m);
    launch_valid = 1; launch_mask = m; tick();
  endtask

  task automatic do_issue(input int t, input bit st, input int cyc, input bit ret);
    issue_valid = 1; issue_thread = TW'(t); issue_stall = st;
    issue_stall_cycles = SCW'(cyc); issue_retire = ret; tick();
  endtask

  task automatic test_reset();
    reset = 1; m_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    n_checks++; if (active_threads !== 8'h00) $display("FAIL reset_active got %h want 00", active_threads); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (launch_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", launch_ready); else n_pass++;
    n_checks++; if (done !== 1'b0 || issue_err !== 1'b0) $display("FAIL reset_pulses got done=%b err=%b want 0 0", done, issue_err); else n_pass++;
  endtask

  task automatic test_launch_stall_retire();
    do_launch(8'h05);
    n_checks++; if (active_threads !== 8'h05) $display("FAIL launch_active got %h want 05", active_threads); else n_pass++;
    n_checks++; if (busy !== 1'b1 || launch_ready !== 1'b0) $display("FAIL launch_busy got busy=%b ready=%b want 1 0", busy, launch_ready); else n_pass++;
    do_issue(0, 1, 3, 0);
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (active_threads !== 8'h04) $display("FAIL stall3_cycle%0d got %h want 04", c, active_threads); else n_pass++;
      if (c < 2) tick();
    end
    tick();
    n_checks++; if (active_threads !== 8'h05) $display("FAIL stall3_return got %h want 05", active_threads); else n_pass++;
    do_issue(2, 0, 0, 1);
    n_checks++; if (active_threads !== 8'h01 || done !== 1'b0) $display("FAIL retire2 got %h done=%b want 01 0", active_threads, done); else n_pass++;
    do_issue(0, 0, 0, 1);
    n_checks++; if (active_threads !== 8'h00 || busy !== 1'b0) $display("FAIL retire0 got %h busy=%b want 00 0", active_threads, busy); else n_pass++;
    n_checks++; if (done !== 1'b1 || launch_ready !== 1'b1) $display("FAIL group_done got done=%b ready=%b want 1 1", done, launch_ready); else n_pass++;
    tick();
    n_checks++; if (done !== 1'b0) $display("FAIL done_width got %b want 0", done); else n_pass++;
  endtask

  task automatic test_illegal_issue();
    do_issue(2, 0, 0, 0);
    n_checks++; if (issue_err !== 1'b1 || active_threads !== 8'h00) $display("FAIL err_idle got err=%b act=%h want 1 00", issue_err, active_threads); else n_pass++;
    tick();
    n_checks++; if (issue_err !== 1'b0) $display("FAIL err_width got %b want 0", issue_err); else n_pass++;
    do_issue(9, 0, 0, 1);
    n_checks++; if (issue_err !== 1'b1 || busy !== 1'b0) $display("FAIL err_range got err=%b busy=%b want 1 0", issue_err, busy); else n_pass++;
    do_launch(8'h00);
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || launch_ready !== 1'b1) $display("FAIL zero_mask got busy=%b done=%b ready=%b want 0 0 1", busy, done, launch_ready); else n_pass++;
    tick();
    n_checks++; if (done !== 1'b0) $display("FAIL zero_mask_done got %b want 0", done); else n_pass++;
  endtask

  task automatic test_busy_launch_midreset();
    do_launch(8'h05);
    do_issue(0, 1, 5, 0);
    do_launch(8'hFF);
    n_checks++; if (active_threads !== 8'h04 || busy !== 1'b1) $display("FAIL busy_launch got %h busy=%b want 04 1", active_threads, busy); else n_pass++;
    #2 reset = 1; m_reset();
    #1;
    n_checks++; if (active_threads !== 8'h00 || busy !== 1'b0 || launch_ready !== 1'b1) $display("FAIL midreset got act=%h busy=%b ready=%b want 00 0 1", active_threads, busy, launch_ready); else n_pass++;
    n_checks++; if (done !== 1'b0 || issue_err !== 1'b0) $display("FAIL midreset_pulses got done=%b err=%b want 0 0", done, issue_err); else n_pass++;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++; if (done !== 1'b0 || active_threads !== 8'h00) $display("FAIL post_reset%0d got done=%b act=%h want 0 00", c, done, active_threads); else n_pass++;
    end
  endtask

  task automatic test_concurrent_stall();
    logic [NT-1:0] exp_act[7] = '{8'h0A, 8'h08, 8'h00, 8'h02, 8'h02, 8'h02, 8'h02};
    do_launch(8'h0A);
    n_checks++; if (active_threads !== exp_act[0]) $display("FAIL conc_launch got %h want %h", active_threads, exp_act[0]); else n_pass++;
    do_issue(1, 1, 2, 0);
    n_checks++; if (active_threads !== exp_act[1]) $display("FAIL conc_t1 got %h want %h", active_threads, exp_act[1]); else n_pass++;
    do_issue(3, 1, 5, 0);
    n_checks++; if (active_threads !== exp_act[2]) $display("FAIL conc_t3 got %h want %h", active_threads, exp_act[2]); else n_pass++;
    for (int c = 3; c < 7; c++) begin
      tick();
      n_checks++; if (active_threads !== exp_act[c]) $display("FAIL conc_step%0d got %h want %h", c, active_threads, exp_act[c]); else n_pass++;
    end
    tick();
    n_checks++; if (active_threads !== 8'h0A) $display("FAIL conc_both got %h want 0A", active_threads); else n_pass++;
    do_issue(1, 0, 0, 1);
    do_issue(3, 0, 0, 1);
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL conc_done got done=%b busy=%b want 1 0", done, busy); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      launch_valid       = ($urandom_range(0, 7) == 0);
      launch_mask        = NT'($urandom);
      issue_valid        = ($urandom_range(0, 1) == 1);
      issue_thread       = TW'($urandom_range(0, 9));
      issue_stall        = ($urandom_range(0, 2) == 0);
      issue_stall_cycles = SCW'($urandom_range(0, 7));
      issue_retire       = ($urandom_range(0, 5) == 0);
      tick();
      n_checks++;
      if (active_threads !== m_active() || busy !== m_busy() || launch_ready !== !m_busy() ||
          done !== m_done || issue_err !== m_err)
        $display("FAIL rand_cycle%0d got act=%h busy=%b rdy=%b done=%b err=%b want act=%h busy=%b rdy=%b done=%b err=%b",
                 c, active_threads, busy, launch_ready, done, issue_err,
                 m_active(), m_busy(), !m_busy(), m_done, m_err);
      else n_pass++;
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_launch_stall_retire();
    test_illegal_issue();
    test_busy_launch_midreset();
    test_concurrent_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/thread_status_unit.md
THREAD_STATUS_UNIT -- requirements
Module: thread_status_unit

Interface
REQ-001 SHALL have parameter NUM_THREADS, default 8, number of hardware threads tracked.
REQ-002 SHALL have parameter THREAD_ID_WIDTH, default 3, width of a thread index (log2 NUM_THREADS).
REQ-003 SHALL have parameter STALL_CNT_WIDTH, default 4, width of stall-cycle count.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port launch_valid  input  1  new thread group offered.
REQ-007 SHALL have port launch_mask  input  NUM_THREADS  threads to start; bit i = thread i.
REQ-008 SHALL have port launch_ready  output  1  unit can accept a launch.
REQ-009 SHALL have port issue_valid  input  1  scheduler issued an instruction this cycle.
REQ-010 SHALL have port issue_thread  input  THREAD_ID_WIDTH  issued thread index.
REQ-011 SHALL have port issue_stall  input  1  issued instruction stalls its thread.
REQ-012 SHALL have port issue_stall_cycles  input  STALL_CNT_WIDTH  stall length in cycles.
REQ-013 SHALL have port issue_retire  input  1  issued instruction is the thread's exit.
REQ-014 SHALL have port active_threads  output  NUM_THREADS  mask of READY threads, feeds the round-robin scheduler.
REQ-015 SHALL have port busy  output  1  at least one thread READY or STALL.
REQ-016 SHALL have port done  output  1  one-cycle pulse: group completed.
REQ-017 SHALL have port issue_err  output  1  one-cycle pulse: illegal issue.

Function
REQ-018 SHALL keep per thread a 2-bit state IDLE/READY/STALL/DONE plus a STALL_CNT_WIDTH down-counter.
REQ-019 SHALL drive active_threads[i]=1 iff thread i is READY; busy = OR over READY|STALL; both decoded from registers only, no combinational path from inputs.
REQ-020 SHALL drive launch_ready = !busy.
REQ-021 Launch accept = launch_valid && launch_ready; at that edge masked threads -> READY, all others -> IDLE, counters cleared.
REQ-022 launch_valid while busy SHALL be ignored (no state change); all-zero mask SHALL be accepted, leave busy=0, no done pulse.
REQ-023 Issue SHALL be legal only if issue_valid, issue_thread < NUM_THREADS, and that thread is READY; otherwise issue_valid SHALL cause no state change and issue_err=1 the next cycle.
REQ-024 Legal issue with issue_retire=1: thread -> DONE (retire takes priority over stall).
REQ-025 Legal issue, issue_stall=1, cycles=N>0: thread -> STALL, counter=N; each edge in STALL decrements; at the edge where counter==1, thread -> READY, counter=0; active bit low for exactly N cycles.
REQ-026 Legal issue, issue_stall=1, cycles=0, or no stall/retire: thread stays READY.
REQ-027 Threads in STALL SHALL count down independently and concurrently.
REQ-028 done SHALL be registered, high for one cycle after the edge where busy goes 1->0 due to a retire.
REQ-029 Launch and issue in the same cycle: launch processed; issue is necessarily illegal (no READY thread) and flags issue_err.

Reset
REQ-030 On reset all threads SHALL be IDLE, counters 0; active_threads=0, busy=0, done=0, issue_err=0, launch_ready=1.
REQ-031 Reset asserted mid-operation SHALL abort all threads immediately, no done pulse.

Verification
REQ-032 Reset, launch_mask=8'b0000_0101 -> next cycle active_threads=8'h05, busy=1, launch_ready=0.
REQ-033 Thread 0 issued with stall, cycles=3 -> active_threads=8'h04 for exactly 3 cycles, then 8'h05.
REQ-034 Retire thread 2, then thread 0 -> active_threads 8'h01 then 8'h00; busy falls; done=1 for one cycle; launch_ready=1.
REQ-035 Issue thread 2 while IDLE, and issue_thread=9 with NUM_THREADS=8 -> issue_err pulse each, no state change.
REQ-036 Launch 8'hFF while busy -> ignored; then reset mid-stall -> all outputs at reset values, no done.
REQ-037 Threads 1 and 3 stalled 2 and 5 cycles on consecutive issues -> each returns READY after its own count.
